// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared TDM framing constants and types, used by the mux and
//               demux sides of the 4-to-1 TDM path.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

  typedef logic [1:0] tdm_slot_t;

  localparam tdm_slot_t SLOT_A    = 2'd0;
  localparam tdm_slot_t SLOT_B    = 2'd1;
  localparam tdm_slot_t SLOT_C    = 2'd2;
  localparam tdm_slot_t SLOT_D    = 2'd3;
  localparam int        FRAME_LEN = 4;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_ctrl
// Description : Frame alignment FSM and slot counter; emits per-slot write
//               enables, frame commit and framing-error indications.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_ctrl
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_sync,
  output logic [FRAME_LEN-1:0] o_we,
  output logic                 o_commit,
  output logic                 o_err_evt,
  output logic                 o_sync_err,
  output logic [1:0]           o_sel,
  output logic                 o_locked
);

  tdm_state_e r_state, w_state_nxt;
  tdm_slot_t  r_sel, w_sel_nxt;
  logic       r_sync_err;
  logic       r_locked;
  logic       w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_sel      <= SLOT_A;
      r_sync_err <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sel      <= w_sel_nxt;
      r_sync_err <= w_err;
      r_locked   <= (w_state_nxt == ST_LOCKED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    o_we        = '0;
    o_commit    = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (i_valid && i_sync) begin
          o_we[SLOT_A] = 1'b1;
          w_sel_nxt    = SLOT_B;
          w_state_nxt  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (i_valid) begin
          if (r_sel == SLOT_A) begin
            if (i_sync) begin
              o_we[SLOT_A] = 1'b1;
              w_sel_nxt    = SLOT_B;
            end else begin
              w_err       = 1'b1;
              w_state_nxt = ST_HUNT;
            end
          end else if (i_sync) begin
            // Early sync: realign on this word, abandoning the partial frame
            w_err        = 1'b1;
            o_we[SLOT_A] = 1'b1;
            w_sel_nxt    = SLOT_B;
          end else begin
            o_we[r_sel] = 1'b1;
            w_sel_nxt   = r_sel + 2'd1;
            o_commit    = (r_sel == SLOT_D);
          end
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_sel_nxt   = SLOT_A;
      end
    endcase
  end

  assign o_err_evt  = w_err;
  assign o_sync_err = r_sync_err;
  assign o_sel      = r_sel;
  assign o_locked   = r_locked;

endmodule : tdm_slot_ctrl
`default_nettype wire

// File: rtl/tdm_demux_4to1.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_4to1
// Description : De-interleaves a TDM word stream into four channels and
//               presents complete frames atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_4to1
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             frame_valid,
  output logic [1:0]       sel,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_count
);

  logic [FRAME_LEN-1:0] w_we;
  logic                 w_commit;
  logic                 w_err_evt;

  logic [WIDTH-1:0] r_stage [FRAME_LEN];
  logic [WIDTH-1:0] r_out   [FRAME_LEN];
  logic             r_frame_valid;
  logic [ERR_W-1:0] r_err_count;

  tdm_slot_ctrl u_slot_ctrl (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (in_valid),
    .i_sync     (in_sync),
    .o_we       (w_we),
    .o_commit   (w_commit),
    .o_err_evt  (w_err_evt),
    .o_sync_err (sync_err),
    .o_sel      (sel),
    .o_locked   (locked)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        if (w_we[i]) r_stage[i] <= in_data;
      end
    end
  end

  // Outputs load on the D-word edge, bypassing stage D, for one-cycle latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_out[i] <= '0;
      end
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      if (w_commit) begin
        r_out[SLOT_A] <= r_stage[SLOT_A];
        r_out[SLOT_B] <= r_stage[SLOT_B];
        r_out[SLOT_C] <= r_stage[SLOT_C];
        r_out[SLOT_D] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_err_evt && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign out_a       = r_out[SLOT_A];
  assign out_b       = r_out[SLOT_B];
  assign out_c       = r_out[SLOT_C];
  assign out_d       = r_out[SLOT_D];
  assign frame_valid = r_frame_valid;
  assign err_count   = r_err_count;

endmodule : tdm_demux_4to1
`default_nettype wire

// File: tb/tb_tdm_demux_4to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux_4to1
// Description : Directed self-checking bench for the TDM 4-to-1 demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_4to1;

  localparam int WIDTH = 4;
  localparam int ERR_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] out_a, out_b, out_c, out_d;
  logic             frame_valid;
  logic [1:0]       sel;
  logic             locked;
  logic             sync_err;
  logic [ERR_W-1:0] err_count;

  int n_vec = 0;
  int n_err = 0;

  tdm_demux_4to1 #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sync     (in_sync),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_d       (out_d),
    .frame_valid (frame_valid),
    .sel         (sel),
    .locked      (locked),
    .sync_err    (sync_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one input beat, then sample #1 after the edge that consumed it
  task automatic send(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  task automatic idle();
    send(1'b0, 1'b0, '0);
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] exp);
    chk({tag, "_fv"}, frame_valid, 1);
    chk({tag, "_out"}, {out_a, out_b, out_c, out_d}, exp);
  endtask

  initial begin
    int fv_cyc [$];
    int cyc;
    logic [3:0] w;

    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;
    idle(); rst = 1'b1; idle();
    chk("rst_sel", sel, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_out", {out_a, out_b, out_c, out_d}, 16'h0000);
    chk("rst_err", {sync_err, err_count}, 0);
    rst = 1'b0;

    // Single frame 1,0,1,1
    send(1, 1, 4'h1);
    chk("t1_locked", locked, 1);
    chk("t1_sel1", sel, 1);
    send(1, 0, 4'h0);
    chk("t1_sel2", sel, 2);
    send(1, 0, 4'h1);
    chk("t1_sel3", sel, 3);
    chk("t1_nofv", frame_valid, 0);
    send(1, 0, 4'h1);
    chk_frame("t1", 16'h1011);
    chk("t1_sel0", sel, 0);
    idle();
    chk("t1_fv_pulse", frame_valid, 0);

    // Gapped input
    send(1, 1, 4'hA); idle(); idle();
    chk("t2_gap_sel1", sel, 1);
    send(1, 0, 4'h5); idle(); idle();
    chk("t2_gap_sel2", sel, 2);
    send(1, 0, 4'h3); idle(); idle();
    chk("t2_gap_sel3", sel, 3);
    chk("t2_gap_nofv", frame_valid, 0);
    send(1, 0, 4'hC);
    chk_frame("t2", 16'hA53C);

    // Early sync realigns on the 7 word
    send(1, 1, 4'h1);
    send(1, 0, 4'h2);
    chk("t3_sel2", sel, 2);
    send(1, 1, 4'h7);
    chk("t3_serr", sync_err, 1);
    chk("t3_errcnt", err_count, 1);
    chk("t3_sel", sel, 1);
    chk("t3_locked", locked, 1);
    chk("t3_nofv", frame_valid, 0);
    send(1, 0, 4'h8);
    chk("t3_serr_pulse", sync_err, 0);
    send(1, 0, 4'h9);
    chk("t3_nofv2", frame_valid, 0);
    send(1, 0, 4'hF);
    chk_frame("t3", 16'h789F);

    // Missed sync
    send(1, 0, 4'h3);
    chk("t4_serr", sync_err, 1);
    chk("t4_unlock", locked, 0);
    chk("t4_errcnt", err_count, 2);
    send(1, 0, 4'h4);
    send(1, 0, 4'h5);
    chk("t4_hunt", {locked, sel}, 3'b000);
    chk("t4_serr_once", sync_err, 0);
    chk("t4_errcnt_hold", err_count, 2);
    send(1, 1, 4'h6);
    chk("t4_relock", {locked, sel}, 3'b101);

    // Reset mid-frame
    send(1, 0, 4'h1);
    send(1, 0, 4'h2);
    rst = 1'b1; idle(); rst = 1'b0;
    chk("t5_rst_out", {out_a, out_b, out_c, out_d}, 16'h0000);
    chk("t5_rst_state", {locked, sel, frame_valid, err_count}, 0);

    // Three back-to-back frames at one word per cycle
    cyc = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        w = 4'(f * 4 + k);
        send(1, (k == 0), w);
        cyc++;
        if (frame_valid) fv_cyc.push_back(cyc);
      end
    end
    idle();
    if (frame_valid) fv_cyc.push_back(cyc + 1);
    chk("t5_fv_count", fv_cyc.size(), 3);
    if (fv_cyc.size() == 3) begin
      chk("t5_first_fv", fv_cyc[0], 4);
      chk("t5_space1", fv_cyc[1] - fv_cyc[0], 4);
      chk("t5_space2", fv_cyc[2] - fv_cyc[1], 4);
    end
    chk("t5_last_out", {out_a, out_b, out_c, out_d}, 16'h89AB);

    // Five missed-sync events saturate the 2-bit counter at 3
    for (int e = 0; e < 5; e++) begin
      send(1, 1, 4'h1);
      send(1, 0, 4'h2);
      send(1, 0, 4'h3);
      send(1, 0, 4'h4);
      send(1, 0, 4'h5);
      chk("t6_serr", sync_err, 1);
      chk("t6_errcnt", err_count, (e < 3) ? e + 1 : 3);
    end
    idle(); idle();
    chk("t6_errcnt_hold", err_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_tdm_demux_4to1
`default_nettype wire

// File: doc/tdm_demux_4to1.md
Name: tdm_demux_4to1

Overview:
- Receive end of the team's 4-to-1 TDM multiplexing path: accepts one time-multiplexed word stream and de-interleaves it into four channels A, B, C, D.
- A frame is four consecutive valid words. The channel-A slot is marked by a sync flag.
- Sits downstream of the mux-based serializer. It regenerates the 2-bit slot select {S1,S0} internally and presents complete frames atomically to downstream logic.

Parameters:
- WIDTH, 1, bit width of each channel word.
- ERR_W, 8, width of the saturating sync-error counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  multiplexed input word.
- in_valid  input  1  in_data is valid this cycle.
- in_sync  input  1  qualifies the current valid word as the channel-A slot; ignored when in_valid=0.
- out_a  output  WIDTH  channel A word of the last complete frame.
- out_b  output  WIDTH  channel B word of the last complete frame.
- out_c  output  WIDTH  channel C word of the last complete frame.
- out_d  output  WIDTH  channel D word of the last complete frame.
- frame_valid  output  1  one-cycle pulse when out_a..out_d update.
- sel  output  2  current slot select {S1,S0}: 0=A, 1=B, 2=C, 3=D.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing violation.
- err_count  output  ERR_W  saturating count of sync_err pulses.

Behaviour:
- Reset: rst sampled high at a rising edge clears the following.
  - State to HUNT; sel=0.
  - Staging registers and out_a..out_d to 0.
  - frame_valid=0, sync_err=0, locked=0, err_count=0.
  - Reset mid-frame discards the partial frame. Reset has priority over all inputs.
- State machine, two states: HUNT and LOCKED.
- HUNT:
  - Words are dropped until in_valid=1 with in_sync=1.
  - That word is stored to stage A; sel goes to 1; next state is LOCKED.
  - in_valid=1 with in_sync=0 is dropped silently: no sync_err.
- LOCKED, on each in_valid=1 cycle (in_valid=0 cycles hold all state; gaps of any length are allowed):
  - sel=0 and in_sync=1: store to stage A, sel goes to 1.
  - sel=0 and in_sync=0: missed sync. Pulse sync_err, drop the word, go to HUNT.
  - sel in 1..2 and in_sync=0: store to stage B or C, sel increments.
  - sel=3 and in_sync=0: store to stage D, sel wraps to 0, commit the frame.
  - sel in 1..3 and in_sync=1: early sync. Pulse sync_err and discard the partial frame. Realign: the word goes to stage A, sel goes to 1, stay LOCKED, no frame_valid.
- Frame commit:
  - On the cycle after the D word is accepted, out_a..out_d take stages A..D simultaneously and frame_valid pulses high for exactly that cycle.
  - Latency is 1 cycle from D-word acceptance to outputs.
  - Outputs hold otherwise; a partial frame never reaches the outputs.
- Back-to-back frames: an A word in the commit cycle is accepted normally, so a sustained rate of 1 frame per 4 cycles is supported.
- Registered pulses: sync_err is registered, asserted the cycle after the offending word. frame_valid and sync_err may both be high in the same cycle.
- err_count increments on each sync_err and saturates at 2^ERR_W-1 with no wrap.
- locked equals (state==LOCKED), registered.
- Width rules: sel is a 2-bit counter with natural wrap from 3 to 0. No arithmetic on data.

Decomposition:
- Shared package tdm_pkg: state encoding (ST_HUNT=1'b0, ST_LOCKED=1'b1), slot constants (SLOT_A..SLOT_D = 2'd0..2'd3), and FRAME_LEN=4. The same package is to be reused by the transmit-side TDM serializer.
- One natural sub-module, tdm_slot_ctrl: the FSM plus the sel counter plus sync checking. It produces a per-slot write enable, commit, and sync_err.
- The top level holds the staging and output registers and err_count.

Test Plan:
- Reset then single frame: rst for 2 cycles. Send words 1,0,1,1 with in_sync only on the first, in_valid continuous. Required: locked=1 after word 1; frame_valid pulses 1 cycle after word 4 with out_a=1, out_b=0, out_c=1, out_d=1; sel sequence 0,1,2,3,0.
- Gapped input, WIDTH=4: words 4'hA, 4'h5, 4'h3, 4'hC with 2 idle (in_valid=0) cycles between each. Required: sel holds during gaps; one frame_valid with out_a..d = A,5,3,C.
- Early sync: after A and B words (sel=2), a valid word 4'h7 with in_sync=1, then 3 more words. Required: sync_err pulse, err_count=1, no frame_valid for the broken frame; next frame has out_a=7.
- Missed sync: a complete frame, then a word at sel=0 with in_sync=0. Required: sync_err pulse, locked drops to 0; subsequent non-sync words ignored; a sync word relocks.
- Reset mid-frame: after 3 words, rst for 1 cycle. Required: outputs 0, sel=0, locked=0, no frame_valid. Then a back-to-back stream of 3 frames at 1 word/cycle: 3 frame_valid pulses spaced exactly 4 cycles apart.
- Error saturation, ERR_W=2: force 5 missed-sync events. Required: err_count reads 3 and holds at 3.
